// File: rtl/fde_pkg.sv
// Shared definitions for the fetch/decode/execute pipeline:
// opcodes, the NOP word, fetch states and opcode field slices.
package fde_pkg;

  localparam logic [5:0] OP_ADD = 6'h00;
  localparam logic [5:0] OP_SUB = 6'h01;
  localparam logic [5:0] OP_AND = 6'h02;
  localparam logic [5:0] OP_OR  = 6'h03;
  localparam logic [5:0] OP_XOR = 6'h04;
  localparam logic [5:0] OP_SLL = 6'h05;
  localparam logic [5:0] OP_SRL = 6'h06;
  localparam logic [5:0] OP_SRA = 6'h07;
  localparam logic [5:0] OP_LW  = 6'h08;
  localparam logic [5:0] OP_SW  = 6'h09;
  localparam logic [5:0] OP_BEQ = 6'h0A;
  localparam logic [5:0] OP_BNE = 6'h0B;
  localparam logic [5:0] OP_MUL = 6'h0C;
  localparam logic [5:0] OP_HLT = 6'h0D;
  localparam logic [5:0] OP_NOP = 6'h0E;

  localparam logic [31:0] NOP_WORD = 32'h3800_0000;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_imem.sv
// Instruction memory: DEPTH x 32 words, async read, sync write.
// Ports: i_clk, i_we/i_waddr/i_wdata load port, i_raddr/o_rdata fetch port.
module fetch_imem #(
  parameter int DEPTH = 256
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [31:0]              i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [31:0]              o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, RUN/HALT FSM and the 64-bit IF_ID register.
// Ports: clock, reset_n, stall, br_taken/br_target, imem load port,
// IF_ID {pc, instr}, if_valid, halted.
module fetch_unit
  import fde_pkg::*;
#(
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          stall,
  input  logic                          br_taken,
  input  logic [31:0]                   br_target,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
  input  logic [31:0]                   imem_wdata,
  output logic [63:0]                   IF_ID,
  output logic                          if_valid,
  output logic                          halted
);

  localparam int AW = $clog2(IMEM_DEPTH);

  fetch_state_t r_state;
  fetch_state_t w_state_nx;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_nx;
  logic [63:0]  r_if_id;
  logic [63:0]  w_if_id_nx;
  logic         r_valid;
  logic         w_valid_nx;
  logic [31:0]  w_instr;
  logic         w_is_hlt;

  fetch_imem #(
    .DEPTH (IMEM_DEPTH)
  ) u_imem (
    .i_clk   (clock),
    .i_we    (imem_we),
    .i_waddr (imem_addr),
    .i_wdata (imem_wdata),
    .i_raddr (r_pc[AW+1:2]),
    .o_rdata (w_instr)
  );

  assign w_is_hlt = (w_instr[OPC_HI:OPC_LO] == OP_HLT);

  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_if_id_nx = r_if_id;
    w_valid_nx = r_valid;
    // Redirect beats stall and HALT so a wrong-path HLT is squashed.
    if (br_taken) begin
      w_state_nx = RUN;
      w_pc_nx    = br_target;
      w_if_id_nx = {32'h0, NOP_WORD};
      w_valid_nx = 1'b0;
    end else if (!stall) begin
      unique case (r_state)
        RUN: begin
          w_if_id_nx = {r_pc, w_instr};
          w_valid_nx = 1'b1;
          if (w_is_hlt) begin
            w_state_nx = HALT;
          end else begin
            w_pc_nx = r_pc + 32'd4;
          end
        end
        HALT: begin
          w_if_id_nx = {32'h0, NOP_WORD};
          w_valid_nx = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= RUN;
      r_pc    <= RESET_PC;
      r_if_id <= {32'h0, NOP_WORD};
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_pc    <= w_pc_nx;
      r_if_id <= w_if_id_nx;
      r_valid <= w_valid_nx;
    end
  end

  assign IF_ID    = r_if_id;
  assign if_valid = r_valid;
  assign halted   = (r_state == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table, directed
// corner sequences and randomized run against a reference model.
module tb_fetch_unit;

  localparam int D = 256;
  localparam logic [31:0] NOP = 32'h3800_0000;
  localparam logic [63:0] BUB = {32'h0, NOP};

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        imem_we = 1'b0;
  logic [7:0]  imem_addr = 8'h0;
  logic [31:0] imem_wdata = 32'h0;
  logic [63:0] IF_ID;
  logic        if_valid;
  logic        halted;

  fetch_unit #(
    .IMEM_DEPTH (D),
    .RESET_PC   (32'h0)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .IF_ID      (IF_ID),
    .if_valid   (if_valid),
    .halted     (halted)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_tot = 0;

  logic [31:0] m_mem [D];
  logic [31:0] m_pc = 32'h0;
  logic [63:0] m_out = BUB;
  logic        m_v = 1'b0;
  logic        m_h = 1'b0;

  typedef struct {
    logic        st;
    logic        br;
    logic [31:0] tgt;
    logic [63:0] exp;
    logic        ev;
    logic        eh;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".if_id"}, IF_ID, m_out);
    chk({tag, ".valid"}, {63'h0, if_valid}, {63'h0, m_v});
    chk({tag, ".halted"}, {63'h0, halted}, {63'h0, m_h});
  endtask

  // Reference: fetch rules applied in priority order at each edge.
  task automatic model_edge();
    logic [31:0] w;
    w = m_mem[m_pc[9:2]];
    if (!reset_n) begin
      m_pc = 32'h0; m_out = BUB; m_v = 0; m_h = 0;
    end else if (br_taken) begin
      m_pc = br_target; m_out = BUB; m_v = 0; m_h = 0;
    end else if (stall) begin
      m_pc = m_pc;
    end else if (m_h) begin
      m_out = BUB; m_v = 0;
    end else begin
      m_out = {m_pc, w};
      m_v = 1;
      if (w[31:26] == 6'h0D) m_h = 1;
      else m_pc = m_pc + 32'd4;
    end
    if (imem_we) m_mem[imem_addr] = imem_wdata;
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic load(input int a, input logic [31:0] d);
    imem_we = 1; imem_addr = 8'(a); imem_wdata = d;
    tick();
    imem_we = 0;
  endtask

  task automatic idle();
    stall = 0; br_taken = 0; imem_we = 0;
  endtask

  initial begin
    vt[0] = '{0, 0, 0, {32'd0,  32'h0000_0001}, 1, 0};
    vt[1] = '{0, 0, 0, {32'd4,  32'h0400_0002}, 1, 0};
    vt[2] = '{0, 0, 0, {32'd8,  32'h0800_0003}, 1, 0};
    vt[3] = '{1, 0, 0, {32'd8,  32'h0800_0003}, 1, 0};
    vt[4] = '{1, 0, 0, {32'd8,  32'h0800_0003}, 1, 0};
    vt[5] = '{1, 0, 0, {32'd8,  32'h0800_0003}, 1, 0};
    vt[6] = '{0, 0, 0, {32'd12, 32'h1800_0004}, 1, 0};
    vt[7] = '{0, 1, 32'h40, BUB, 0, 0};
    vt[8] = '{0, 0, 0, {32'h40, 32'h2C00_0005}, 1, 0};
    vt[9] = '{0, 0, 0, {32'h44, 32'h1000_0007}, 1, 0};

    // Loads happen while reset is held.
    load(0, 32'h0000_0001);
    load(1, 32'h0400_0002);
    load(2, 32'h0800_0003);
    load(3, 32'h1800_0004);
    load(4, 32'h0C00_0006);
    load(16, 32'h2C00_0005);
    load(17, 32'h1000_0007);
    chk("rst.if_id", IF_ID, BUB);
    chk("rst.valid", {63'h0, if_valid}, 64'h0);
    chk("rst.halted", {63'h0, halted}, 64'h0);

    reset_n = 1;
    for (int i = 0; i < 10; i++) begin
      stall = vt[i].st;
      br_taken = vt[i].br;
      br_target = vt[i].tgt;
      tick();
      chk($sformatf("vec%0d.if_id", i), IF_ID, vt[i].exp);
      chk($sformatf("vec%0d.valid", i),
          {63'h0, if_valid}, {63'h0, vt[i].ev});
      chk($sformatf("vec%0d.halted", i),
          {63'h0, halted}, {63'h0, vt[i].eh});
    end
    idle();

    // HLT at word 2, then restart via branch to 0.
    reset_n = 0;
    load(2, 32'h3400_0000);
    reset_n = 1;
    tick(); chk_model("hlt0");
    tick(); chk_model("hlt1");
    tick();
    chk("hlt.word", IF_ID, {32'd8, 32'h3400_0000});
    chk("hlt.valid", {63'h0, if_valid}, 64'h1);
    chk("hlt.halted", {63'h0, halted}, 64'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hlt.bubble", IF_ID, BUB);
      chk("hlt.bvalid", {63'h0, if_valid}, 64'h0);
      chk("hlt.bhalted", {63'h0, halted}, 64'h1);
    end
    stall = 1; tick(); chk_model("hlt.stall"); stall = 0;
    br_taken = 1; br_target = 32'h0;
    tick(); br_taken = 0;
    chk("rs.bubble", IF_ID, BUB);
    chk("rs.halted", {63'h0, halted}, 64'h0);
    tick();
    chk("rs.first", IF_ID, {32'd0, 32'h0000_0001});
    chk("rs.valid", {63'h0, if_valid}, 64'h1);

    // Reset overrides stall and branch.
    reset_n = 0; stall = 1; br_taken = 1; br_target = 32'h80;
    tick();
    chk("mrst.if_id", IF_ID, BUB);
    chk("mrst.valid", {63'h0, if_valid}, 64'h0);
    chk("mrst.halted", {63'h0, halted}, 64'h0);
    reset_n = 1; idle();
    tick();
    chk("mrst.first", IF_ID, {32'd0, 32'h0000_0001});

    // Write to the index being fetched this cycle (word 1).
    imem_we = 1; imem_addr = 8'd1; imem_wdata = 32'h2000_00AA;
    tick(); imem_we = 0;
    chk("wcol.old", IF_ID, {32'd4, 32'h0400_0002});
    br_taken = 1; br_target = 32'h4;
    tick(); br_taken = 0;
    chk_model("wcol.bub");
    tick();
    chk("wcol.new", IF_ID, {32'd4, 32'h2000_00AA});

    // Randomized run against the model.
    reset_n = 0;
    for (int a = 0; a < D; a++) begin
      logic [31:0] r;
      r = $urandom;
      r[31:26] = 6'($urandom_range(0, 14));
      load(a, r);
    end
    reset_n = 1;
    for (int c = 0; c < 2000; c++) begin
      reset_n = ($urandom_range(0, 99) >= 3);
      stall = ($urandom_range(0, 99) < 20);
      br_taken = ($urandom_range(0, 99) < 15);
      br_target = $urandom;
      imem_we = ($urandom_range(0, 99) < 20);
      imem_addr = 8'($urandom);
      imem_wdata = $urandom;
      imem_wdata[31:26] = 6'($urandom_range(0, 14));
      tick();
      chk_model("rnd");
    end
    idle();
    reset_n = 1;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
